// File: rtl/sisc_pkg.sv
// Shared widths, index type and constants for the SISC register file slice.
package sisc_pkg;

  localparam int DATA_W   = 32;
  localparam int REG_AW   = 4;
  localparam int NUM_REGS = 2 ** REG_AW;

  typedef logic [REG_AW-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] data_t;

  localparam reg_idx_t R0 = '0;

endpackage

// File: rtl/sisc_scoreboard.sv
// Busy-bit scoreboard for in-flight destinations, with the operand hazard check.
module sisc_scoreboard
  import sisc_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_en,
  input  reg_idx_t            issue_reg,
  input  logic                rf_we,
  input  reg_idx_t            write_reg,
  input  logic                rega_use,
  input  logic                regb_use,
  input  reg_idx_t            read_rega,
  input  reg_idx_t            read_regb,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                hazard
);

  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] busy_q;
  logic                haz_a;
  logic                haz_b;

  // Set is applied after clear so a new producer on the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (rf_we && (write_reg != R0)) begin
      busy_d[write_reg] = 1'b0;
    end
    if (issue_en && (issue_reg != R0)) begin
      busy_d[issue_reg] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // A same-cycle write-back forwards the data, so it cancels the stall.
  always_comb begin
    haz_a  = rega_use & busy_q[read_rega] & ~(rf_we & (write_reg == read_rega));
    haz_b  = regb_use & busy_q[read_regb] & ~(rf_we & (write_reg == read_regb));
    hazard = haz_a | haz_b;
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/sisc_regfile_sb.sv
// SISC register file: write-back commit, two bypassed read ports, and scoreboard.
module sisc_regfile_sb
  import sisc_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_AW-1:0]   read_rega,
  input  logic [REG_AW-1:0]   read_regb,
  input  logic                rega_use,
  input  logic                regb_use,
  output logic [DATA_W-1:0]   rsa,
  output logic [DATA_W-1:0]   rsb,
  input  logic [REG_AW-1:0]   write_reg,
  input  logic [DATA_W-1:0]   write_data,
  input  logic                rf_we,
  input  logic                issue_en,
  input  logic [REG_AW-1:0]   issue_reg,
  output logic                hazard,
  output logic [NUM_REGS-1:0] busy_vec
);

  data_t regs_d [NUM_REGS];
  data_t regs_q [NUM_REGS];
  logic  wr_en;

  assign wr_en = rf_we && (write_reg != R0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[write_reg] = write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // R0 reads as zero; otherwise the in-flight write-back is forwarded ahead of storage.
  always_comb begin
    if (read_rega == R0) begin
      rsa = '0;
    end else if (wr_en && (write_reg == read_rega)) begin
      rsa = write_data;
    end else begin
      rsa = regs_q[read_rega];
    end
    if (read_regb == R0) begin
      rsb = '0;
    end else if (wr_en && (write_reg == read_regb)) begin
      rsb = write_data;
    end else begin
      rsb = regs_q[read_regb];
    end
  end

  sisc_scoreboard u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .issue_en  (issue_en),
    .issue_reg (issue_reg),
    .rf_we     (rf_we),
    .write_reg (write_reg),
    .rega_use  (rega_use),
    .regb_use  (regb_use),
    .read_rega (read_rega),
    .read_regb (read_regb),
    .busy_vec  (busy_vec),
    .hazard    (hazard)
  );

endmodule

// File: tb/tb_sisc_regfile_sb.sv
// Scoreboard bench for sisc_regfile_sb: directed scenarios then random traffic vs an array model.
module tb_sisc_regfile_sb;

  logic        clk;
  logic        rst;
  logic [3:0]  read_rega;
  logic [3:0]  read_regb;
  logic        rega_use;
  logic        regb_use;
  logic [31:0] rsa;
  logic [31:0] rsb;
  logic [3:0]  write_reg;
  logic [31:0] write_data;
  logic        rf_we;
  logic        issue_en;
  logic [3:0]  issue_reg;
  logic        hazard;
  logic [15:0] busy_vec;

  typedef struct {
    logic [31:0] rsa;
    logic [31:0] rsb;
    logic        hazard;
    logic [15:0] busy;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_mem [16];
  bit          m_busy [16];
  int          assert_count = 0;
  int          fail_count   = 0;
  bit          stim_done    = 0;

  sisc_regfile_sb dut (
    .clk        (clk),
    .rst        (rst),
    .read_rega  (read_rega),
    .read_regb  (read_regb),
    .rega_use   (rega_use),
    .regb_use   (regb_use),
    .rsa        (rsa),
    .rsb        (rsb),
    .write_reg  (write_reg),
    .write_data (write_data),
    .rf_we      (rf_we),
    .issue_en   (issue_en),
    .issue_reg  (issue_reg),
    .hazard     (hazard),
    .busy_vec   (busy_vec)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    assert_count++;
    if (act !== req) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Model view of what a port reads: zero for R0, forwarded data, else the stored word.
  function automatic logic [31:0] modelRead(input int idx, input bit we, input int wr, input logic [31:0] wd);
    if (idx == 0) return 32'h0;
    if (we && wr == idx) return wd;
    return m_mem[idx];
  endfunction

  // Drives one cycle of inputs, queues the expected outputs, then advances the model past the edge.
  task automatic applyStimulus(input bit r, input int ra, input int rb, input bit ua, input bit ub,
                               input bit we, input int wr, input logic [31:0] wd,
                               input bit ie, input int ir);
    exp_t e;
    rst = r; read_rega = ra[3:0]; read_regb = rb[3:0]; rega_use = ua; regb_use = ub;
    rf_we = we; write_reg = wr[3:0]; write_data = wd; issue_en = ie; issue_reg = ir[3:0];
    e.rsa    = modelRead(ra, we, wr, wd);
    e.rsb    = modelRead(rb, we, wr, wd);
    e.hazard = (ua && m_busy[ra] && !(we && wr == ra)) || (ub && m_busy[rb] && !(we && wr == rb));
    e.busy   = '0;
    for (int i = 0; i < 16; i++) e.busy[i] = m_busy[i];
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (r) begin
      for (int i = 0; i < 16; i++) begin
        m_mem[i] = 0;
        m_busy[i] = 0;
      end
    end else begin
      if (we && wr != 0) begin
        m_mem[wr] = wd;
        m_busy[wr] = 0;
      end
      if (ie && ir != 0) m_busy[ir] = 1;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("rsa", rsa, e.rsa);
      checkOutput("rsb", rsb, e.rsb);
      checkOutput("hazard", {31'b0, hazard}, {31'b0, e.hazard});
      checkOutput("busy_vec", {16'b0, busy_vec}, {16'b0, e.busy});
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: stimulus_done=%0d, expected 1", stim_done);
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    rst = 1; read_rega = 0; read_regb = 0; rega_use = 0; regb_use = 0;
    rf_we = 0; write_reg = 0; write_data = 0; issue_en = 0; issue_reg = 0;
    for (int i = 0; i < 16; i++) begin
      m_mem[i] = 0;
      m_busy[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;

    // Reset, then read every index on both ports.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) applyStimulus(0, i, 15 - i, 1, 1, 0, 0, 0, 0, 0);

    // Write/readback and R0 write ignored.
    applyStimulus(0, 0, 0, 0, 0, 1, 3, 32'hDEADBEEF, 0, 0);
    applyStimulus(0, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 32'h12345678, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Bypass on port B, then stored value after the edge.
    applyStimulus(0, 0, 0, 0, 0, 1, 5, 32'h11111111, 0, 0);
    applyStimulus(0, 0, 5, 0, 0, 1, 5, 32'h22222222, 0, 0);
    applyStimulus(0, 0, 5, 0, 0, 0, 0, 0, 0, 0);

    // Scoreboard stall on R7 until its write-back.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
    applyStimulus(0, 7, 0, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 7, 0, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 7, 0, 1, 0, 1, 7, 32'hCAFEF00D, 0, 0);
    applyStimulus(0, 7, 0, 1, 0, 0, 0, 0, 0, 0);

    // Simultaneous set/clear, same and different registers.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 4);
    applyStimulus(0, 0, 4, 0, 1, 1, 4, 32'h44444444, 1, 4);
    applyStimulus(0, 4, 4, 1, 1, 1, 4, 32'h55555555, 1, 6);
    applyStimulus(0, 4, 6, 1, 1, 0, 0, 0, 0, 0);

    // Reset mid-operation drops the pending write and busy bits.
    applyStimulus(0, 0, 0, 0, 0, 1, 9, 32'hA5A5A5A5, 1, 2);
    applyStimulus(0, 9, 2, 1, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 9, 2, 1, 1, 1, 9, 32'hFFFFFFFF, 0, 0);
    applyStimulus(0, 9, 2, 1, 1, 0, 0, 0, 0, 0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      applyStimulus($urandom_range(0, 99) < 2,
                    $urandom_range(0, 15), $urandom_range(0, 15),
                    $urandom_range(0, 1), $urandom_range(0, 1),
                    $urandom_range(0, 1), $urandom_range(0, 15), $urandom,
                    $urandom_range(0, 2) == 0, $urandom_range(0, 15));
    end

    @(negedge clk);
    @(negedge clk);
    stim_done = 1;
    checkOutput("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/sisc_regfile_sb.md
Name: sisc_regfile_sb

Overview:
- Register file with write-back scoreboard for the SISC datapath.
- Sits directly downstream of the 32-bit write-back mux, which selects between memory read data and ALU result.
- Commits the mux output to the destination register, and supplies two combinational read ports to the ALU stage.
- Tracks in-flight destinations and raises a hazard when an operand is still pending.

Parameters:
- DATA_W, 32, register/data width
- REG_AW, 4, register address width
- NUM_REGS, 16, register count (2**REG_AW); R0 hardwired to zero

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- read_rega  in  REG_AW  operand A register index
- read_regb  in  REG_AW  operand B register index
- rega_use  in  1  operand A is consumed this cycle (enables hazard check)
- regb_use  in  1  operand B is consumed this cycle
- rsa  out  DATA_W  operand A data
- rsb  out  DATA_W  operand B data
- write_reg  in  REG_AW  write-back destination index
- write_data  in  DATA_W  write-back data (write-back mux output)
- rf_we  in  1  write-back commit strobe
- issue_en  in  1  instruction with destination issued this cycle
- issue_reg  in  REG_AW  destination of issued instruction
- hazard  out  1  operand pending; decode must stall
- busy_vec  out  NUM_REGS  scoreboard bits, bit i = Ri pending

Behaviour:
- Reset:
  - rst=1 at a rising edge clears all registers and all busy bits.
  - Reset takes priority over rf_we and issue_en in the same cycle.
  - After reset: rsa=rsb=0, hazard=0, busy_vec=0.
  - Reset mid-operation discards all pending writes; nothing is committed on the reset edge.
- Write:
  - On a rising edge with rf_we=1 and write_reg!=0, reg[write_reg] <= write_data.
  - write_reg=0 is ignored (no error).
  - Write latency: 1 edge.
- Read:
  - Combinational, zero latency.
  - Index 0 always returns 0.
  - Write-through bypass: if rf_we=1, write_reg==read index and index!=0, the port returns write_data in the same cycle. Otherwise it returns the stored value.
- Scoreboard:
  - Set: issue_en=1 and issue_reg!=0 sets busy[issue_reg] at the edge.
  - Clear: rf_we=1 and write_reg!=0 clears busy[write_reg] at the edge.
  - Set and clear on the same register in the same cycle: set wins, since the new producer is outstanding.
  - Set and clear on different registers in the same cycle: both take effect.
  - Issue to an already-busy register: it stays busy. There is no count, so only one outstanding producer per register is supported; decode guarantees this through the hazard stall.
  - Clear of a non-busy register: no effect.
- Hazard (combinational):
  - hazA = rega_use & busy[read_rega] & ~(rf_we & write_reg==read_rega).
  - hazB is the same form for operand B.
  - hazard = hazA | hazB.
  - A bypass in the same cycle removes the hazard, because the data is forwarded.
  - R0 is never busy, so it never causes a hazard.
- busy_vec is registered; bit 0 is constant 0.
- Widths: all data paths are DATA_W with no extension or truncation. Index comparisons are REG_AW bits.

Decomposition:
- Shared package sisc_pkg:
  - DATA_W, REG_AW, NUM_REGS constants.
  - Register index type.
  - R0 index constant.
- One natural sub-module: sisc_scoreboard.
  - Holds the busy bit vector and its set/clear/priority logic, plus the hazard equation.
  - The top module holds the storage array and bypass read muxes.

Test Plan:
- Reset then read all: rst=1 one cycle, then read_rega=read_regb=0..15 -> rsa=rsb=0x00000000, hazard=0, busy_vec=0x0000.
- Write/readback and R0: rf_we=1, write_reg=3, write_data=0xDEADBEEF; next cycle read_rega=3 -> rsa=0xDEADBEEF. Write 0x12345678 to R0 -> reading R0 returns 0.
- Bypass: R5 holds 0x11111111; in one cycle rf_we=1, write_reg=5, write_data=0x22222222, read_regb=5 -> rsb=0x22222222 that same cycle and 0x22222222 after the edge.
- Scoreboard stall: issue_en=1, issue_reg=7; next cycle rega_use=1, read_rega=7 -> hazard=1, busy_vec=0x0080. Hazard stays 1 until the rf_we write_reg=7 cycle, where hazard=0 and rsa=write_data; busy_vec=0x0000 after that edge.
- Simultaneous set/clear: R4 busy; same cycle issue_en=1 with issue_reg=4 and rf_we=1 with write_reg=4 -> busy_vec bit4=1 after the edge. Repeat with issue_reg=6 -> bit4=0 and bit6=1.
- Reset mid-operation: R2 busy, R9=0xA5A5A5A5; assert rst with rf_we=1, write_reg=9, write_data=0xFFFFFFFF -> next cycle R9=0, busy_vec=0, hazard=0.
